uvma_obi_arbiter: RTL and testbench

N-to-1 OBI arbiter that shares one OBI slave port between NUM_MASTERS requesters. It arbitrates address phases round-robin and records the granted master index in an in-order ID FIFO. It steers each response phase back to the master that issued it. It is used in benches and harnesses wherever several OBI agents or DUT ports drive a single uvma_obi_if slave.

---
 rtl/uvma_obi_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_uvma_obi_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvma_obi_arbiter.sv
// ============================================================================
// uvma_obi_arbiter
//
// N-to-1 OBI arbiter: shares one OBI slave port between NUM_MASTERS masters.
// Address phases are arbitrated round-robin. The slave-side address phase is
// locked while the slave withholds gnt. Each granted master index is queued
// in an in-order ID FIFO, and responses are steered to the FIFO head.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   m_req/m_gnt           per-master address-phase handshake
//   m_addr/m_we/m_be/     packed per-master address-phase fields
//   m_wdata               (master i occupies slice i)
//   m_rvalid              per-master response valid
//   m_rdata/m_err         response data/error, broadcast to all masters
//   s_*                   single OBI slave port
//   outstanding           ID FIFO occupancy (0..MAX_OUTSTANDING)
//   protocol_err          sticky: s_rvalid seen while no response was owed
//
// Optional build macro UVMA_OBI_ARB_FIXED_PRIO_EN: the lowest-index
// requester wins and the round-robin pointer is removed.
// ============================================================================
module uvma_obi_arbiter #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_MASTERS-1:0]                   m_req,
    output logic [NUM_MASTERS-1:0]                   m_gnt,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]        m_addr,
    input  logic [NUM_MASTERS-1:0]                   m_we,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]      m_be,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]        m_wdata,
    output logic [NUM_MASTERS-1:0]                   m_rvalid,
    output logic [DATA_WIDTH-1:0]                    m_rdata,
    output logic                                     m_err,
    output logic                                     s_req,
    input  logic                                     s_gnt,
    output logic [ADDR_WIDTH-1:0]                    s_addr,
    output logic                                     s_we,
    output logic [DATA_WIDTH/8-1:0]                  s_be,
    output logic [DATA_WIDTH-1:0]                    s_wdata,
    input  logic                                     s_rvalid,
    input  logic [DATA_WIDTH-1:0]                    s_rdata,
    input  logic                                     s_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     protocol_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             perr_q;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    // Explicit wrap so that non-power-of-2 depths (and depth 1) stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef UVMA_OBI_ARB_FIXED_PRIO_EN
    function automatic logic [IDX_W-1:0] prio_pick(input logic [NUM_MASTERS-1:0] req);
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k]) begin
                pick  = IDX_W'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb winner = prio_pick(m_req);
`else
    logic [IDX_W-1:0] rr_ptr_q;

    // First requester at or above ptr, wrapping; defaults to ptr when idle.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      cand;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!found && req[cand]) begin
                pick  = IDX_W'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb winner = rr_pick(m_req, rr_ptr_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (push) begin
            rr_ptr_q <= (cur == IDX_W'(NUM_MASTERS - 1)) ? '0 : cur + 1'b1;
        end
    end
`endif

    assign cur        = (state_q == LOCKED) ? sel_q : winner;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_mem[rd_ptr_q];

    // No full-FIFO bypass: a pop in the same cycle does not free a slot early.
    assign s_req = reset_n & m_req[cur] & ~fifo_full;
    assign push  = s_req & s_gnt;
    assign pop   = reset_n & s_rvalid & ~fifo_empty;

    always_comb begin
        s_addr  = '0;
        s_we    = 1'b0;
        s_be    = '0;
        s_wdata = '0;
        m_gnt   = '0;
        if (s_req) begin
            s_addr  = m_addr[cur*ADDR_WIDTH +: ADDR_WIDTH];
            s_we    = m_we[cur];
            s_be    = m_be[cur*BE_WIDTH +: BE_WIDTH];
            s_wdata = m_wdata[cur*DATA_WIDTH +: DATA_WIDTH];
        end
        if (push) m_gnt[cur] = 1'b1;
    end

    always_comb begin
        m_rvalid = '0;
        if (pop) m_rvalid[head_idx] = 1'b1;
    end

    assign m_rdata      = s_rdata;
    assign m_err        = s_err;
    assign outstanding  = count_q;
    assign protocol_err = perr_q;

    // Lock FSM: a request left pending by the slave freezes the selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_req && !s_gnt) state_d = LOCKED;
            LOCKED:  if (push)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && s_req && !s_gnt) sel_q <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cur;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (s_rvalid && fifo_empty) perr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uvma_obi_arbiter.sv
// ============================================================================
// tb_uvma_obi_arbiter
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model (owner queue, optional lock index, round-robin pointer, sticky error)
// predicts every output each cycle.
// ============================================================================
module tb_uvma_obi_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_gnt;
    logic [NM*AW-1:0]  m_addr;
    logic [NM-1:0]     m_we;
    logic [NM*BW-1:0]  m_be;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              m_err;
    logic              s_req;
    logic              s_gnt;
    logic [AW-1:0]     s_addr;
    logic              s_we;
    logic [BW-1:0]     s_be;
    logic [DW-1:0]     s_wdata;
    logic              s_rvalid;
    logic [DW-1:0]     s_rdata;
    logic              s_err;
    logic [CW-1:0]     outstanding;
    logic              protocol_err;

    always #5 clk = ~clk;

    uvma_obi_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_req       (m_req),
        .m_gnt       (m_gnt),
        .m_addr      (m_addr),
        .m_we        (m_we),
        .m_be        (m_be),
        .m_wdata     (m_wdata),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .m_err       (m_err),
        .s_req       (s_req),
        .s_gnt       (s_gnt),
        .s_addr      (s_addr),
        .s_we        (s_we),
        .s_be        (s_be),
        .s_wdata     (s_wdata),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .s_err       (s_err),
        .outstanding (outstanding),
        .protocol_err(protocol_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int q[$];
    int lock_idx = -1;
    int rr = 0;
    bit perr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cand();
        if (lock_idx >= 0) return lock_idx;
        for (int k = 0; k < int'(NM); k++) begin
            int c = (rr + k) % int'(NM);
            if (m_req[c]) return c;
        end
        return -1;
    endfunction

    // One clock: compare combinational outputs mid-cycle, advance the model,
    // then compare registered outputs just after the edge.
    task automatic tick();
        int            cand;
        bit            sreq, hs;
        logic [NM-1:0] eg, ev;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd;
        @(negedge clk);
        cand = model_cand();
        sreq = reset_n && cand >= 0 && m_req[cand] && q.size() < int'(MO);
        hs   = sreq && s_gnt;
        eg   = '0;
        ev   = '0;
        ea   = '0;
        ewe  = 1'b0;
        ebe  = '0;
        ewd  = '0;
        if (hs) eg[cand] = 1'b1;
        if (reset_n && s_rvalid && q.size() > 0) ev[q[0]] = 1'b1;
        if (sreq) begin
            ea  = m_addr[cand*AW +: AW];
            ewe = m_we[cand];
            ebe = m_be[cand*BW +: BW];
            ewd = m_wdata[cand*DW +: DW];
        end
        chk("s_req",    64'(s_req),    64'(sreq));
        chk("m_gnt",    64'(m_gnt),    64'(eg));
        chk("m_rvalid", 64'(m_rvalid), 64'(ev));
        chk("s_addr",   64'(s_addr),   64'(ea));
        chk("s_we",     64'(s_we),     64'(ewe));
        chk("s_be",     64'(s_be),     64'(ebe));
        chk("s_wdata",  64'(s_wdata),  64'(ewd));
        chk("m_rdata",  64'(m_rdata),  64'(s_rdata));
        chk("m_err",    64'(m_err),    64'(s_err));
        if (!reset_n) begin
            q.delete();
            lock_idx = -1;
            rr       = 0;
            perr     = 1'b0;
        end else begin
            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else perr = 1'b1;
            end
            if (hs) begin
                q.push_back(cand);
                rr       = (cand + 1) % int'(NM);
                lock_idx = -1;
            end else if (sreq) begin
                lock_idx = cand;
            end
        end
        @(posedge clk);
        #1;
        chk("outstanding",  64'(outstanding),  64'(q.size()));
        chk("protocol_err", 64'(protocol_err), 64'(perr));
    endtask

    task automatic do_reset(input int n);
        reset_n  = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_err    = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        m_req    = '0;
        m_we     = '0;
        m_be     = '0;
        m_wdata  = '0;
        m_addr   = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_err    = 1'b0;

        // Reset state
        do_reset(2);
        #1;
        chk("rst_sreq",  64'(s_req),        64'(0));
        chk("rst_gnt",   64'(m_gnt),        64'(0));
        chk("rst_outst", 64'(outstanding),  64'(0));
        chk("rst_perr",  64'(protocol_err), 64'(0));

        // Round-robin with both masters requesting, rvalid one cycle after gnt
        m_addr[0*AW +: AW] = 32'h0000_1000;
        m_addr[1*AW +: AW] = 32'h0000_2000;
        m_req = 2'b11;
        s_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_rvalid = (i > 0);
            s_rdata  = $urandom;
            #1;
            chk("rr_gnt", 64'(m_gnt), 64'((i % 2 == 0) ? 1 : 2));
            chk("rr_rvalid", 64'(m_rvalid), 64'((i == 0) ? 0 : (((i - 1) % 2 == 0) ? 1 : 2)));
            tick();
            chk("rr_outst_le1", 64'(outstanding <= 1), 64'(1));
        end

        // Slave withholds gnt: address phase stays locked to master 0
        do_reset(1);
        m_addr[0*AW +: AW] = 32'h0000_0100;
        m_addr[1*AW +: AW] = 32'h0000_0200;
        m_req = 2'b01;
        s_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) m_req = 2'b11;
            #1;
            chk("lock_addr", 64'(s_addr), 64'(32'h100));
            chk("lock_nogn", 64'(m_gnt),  64'(0));
            tick();
        end
        s_gnt = 1'b1;
        #1;
        chk("lock_gnt0",  64'(m_gnt),  64'(1));
        chk("lock_addr0", 64'(s_addr), 64'(32'h100));
        tick();
        #1;
        chk("lock_gnt1",  64'(m_gnt),  64'(2));
        chk("lock_addr1", 64'(s_addr), 64'(32'h200));
        tick();

        // FIFO full: no response until full, first response goes to oldest
        do_reset(1);
        m_req = 2'b01;
        s_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_gnt", 64'(m_gnt), 64'(1));
            tick();
        end
        #1;
        chk("full_sreq",  64'(s_req),       64'(0));
        chk("full_outst", 64'(outstanding), 64'(4));
        tick();
        s_rvalid = 1'b1;
        #1;
        chk("full_rv",    64'(m_rvalid), 64'(1));
        chk("full_nobyp", 64'(s_req),    64'(0));
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("full_reassert", 64'(s_req), 64'(1));
        tick();
        m_req    = '0;
        s_rvalid = 1'b1;
        repeat (4) tick();
        s_rvalid = 1'b0;

        // Response steering: issue order 1,0,1
        do_reset(1);
        s_gnt = 1'b1;
        m_req = 2'b10; #1; chk("ord_g0", 64'(m_gnt), 64'(2)); tick();
        m_req = 2'b01; #1; chk("ord_g1", 64'(m_gnt), 64'(1)); tick();
        m_req = 2'b10; #1; chk("ord_g2", 64'(m_gnt), 64'(2)); tick();
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hA5A5_A5A5;
        s_err    = 1'b0;
        #1;
        chk("ord_rv0", 64'(m_rvalid), 64'(2));
        chk("ord_rd0", 64'(m_rdata),  64'(32'hA5A5_A5A5));
        tick();
        s_err = 1'b1;
        #1;
        chk("ord_rv1",  64'(m_rvalid), 64'(1));
        chk("ord_err1", 64'(m_err),    64'(1));
        tick();
        s_err = 1'b0;
        #1;
        chk("ord_rv2", 64'(m_rvalid), 64'(2));
        tick();
        s_rvalid = 1'b0;

        // Spurious response with nothing outstanding
        do_reset(1);
        s_rvalid = 1'b1;
        #1;
        chk("spur_rv", 64'(m_rvalid), 64'(0));
        tick();
        chk("spur_perr", 64'(protocol_err), 64'(1));
        s_rvalid = 1'b0;
        repeat (2) tick();
        chk("spur_sticky", 64'(protocol_err), 64'(1));
        do_reset(1);
        chk("spur_clear", 64'(protocol_err), 64'(0));

        // Reset with two outstanding and a locked master
        m_req = 2'b01;
        s_gnt = 1'b1;
        repeat (2) tick();
        m_req = 2'b10;
        s_gnt = 1'b0;
        tick();
        chk("rl_outst2", 64'(outstanding), 64'(2));
        reset_n = 1'b0;
        #1;
        chk("rl_sreq_rst", 64'(s_req), 64'(0));
        tick();
        chk("rl_outst0", 64'(outstanding), 64'(0));
        reset_n = 1'b1;
        m_req   = '0;
        #1;
        chk("rl_sreq", 64'(s_req), 64'(0));
        s_rvalid = 1'b1;
        tick();
        chk("rl_perr", 64'(protocol_err), 64'(1));
        s_rvalid = 1'b0;

        // Randomized traffic against the model
        do_reset(1);
        for (int n = 0; n < 600; n++) begin
            m_req = NM'($urandom);
            m_we  = NM'($urandom);
            for (int i = 0; i < int'(NM); i++) begin
                m_addr[i*AW +: AW]  = $urandom;
                m_wdata[i*DW +: DW] = $urandom;
                m_be[i*BW +: BW]    = BW'($urandom);
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
            s_rdata  = $urandom;
            s_err    = 1'($urandom_range(0, 1));
            reset_n  = ($urandom_range(0, 150) != 0);
            tick();
        end
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
